// File: rtl/gp_rf_pkg.sv
// Shared types and default sizes for the GP-Core vector register file.
// Holds the clear-sequencer state encoding and default geometry.
package gp_rf_pkg;

  localparam int GP_RF_NUM_REGS = 8;
  localparam int GP_RF_LANES    = 4;
  localparam int GP_RF_LANE_W   = 32;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_state_e;

endpackage

// File: rtl/gp_rf_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register, reserve handshake.
// Ports: idle, rsv_valid/rsv_addr, wr_clr/waddr, seq_clr/seq_addr -> rsv_ready, busy.
module gp_rf_scoreboard
  import gp_rf_pkg::*;
#(
  parameter int NUM_REGS = GP_RF_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                idle,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                wr_clr,
  input  logic [AW-1:0]       waddr,
  input  logic                seq_clr,
  input  logic [AW-1:0]       seq_addr,
  output logic                rsv_ready,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_nxt;

  assign rsv_ready = idle && !busy[rsv_addr];

  // Applied in order so a reserve overrides a same-address write clear.
  always_comb begin
    busy_nxt = busy;
    if (seq_clr)
      busy_nxt[seq_addr] = 1'b0;
    if (wr_clr)
      busy_nxt[waddr] = 1'b0;
    if (rsv_valid && rsv_ready)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/gp_vector_regfile.sv
// Vector register file: masked write, bypassed reads, scoreboard, bulk clear.
// Ports: raddr/rdata reads, we/waddr/wdata/wmask write, rsv_*, busy, clr_*, wr_drop.
module gp_vector_regfile
  import gp_rf_pkg::*;
#(
  parameter int NUM_REGS = GP_RF_NUM_REGS,
  parameter int LANES    = GP_RF_LANES,
  parameter int LANE_W   = GP_RF_LANE_W,
  parameter int NUM_RD   = 2,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int DATA_W  = LANES * LANE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [LANES-1:0]         wmask,
  input  logic                     rsv_valid,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ready,
  output logic [NUM_REGS-1:0]      busy,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam logic [AW:0] PTR_LAST = (AW+1)'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  rf_state_e         state;
  logic [AW:0]       ptr;
  logic              wr_eff;
  logic              clearing;

  assign wr_eff   = we && (state == RF_IDLE);
  assign clearing = (state == RF_CLEAR);

  gp_rf_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (state == RF_IDLE),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .wr_clr   (wr_eff),
    .waddr    (waddr),
    .seq_clr  (clearing),
    .seq_addr (ptr[AW-1:0]),
    .rsv_ready(rsv_ready),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (clearing) begin
      regs[ptr[AW-1:0]] <= '0;
    end else if (wr_eff) begin
      for (int l = 0; l < LANES; l++)
        if (wmask[l])
          regs[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
    end
  end

  // Masked lanes of an effective write forward straight to matching ports.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdata[p*DATA_W +: DATA_W] = regs[raddr[p*AW +: AW]];
      if (wr_eff && (waddr == raddr[p*AW +: AW])) begin
        for (int l = 0; l < LANES; l++)
          if (wmask[l])
            rdata[p*DATA_W + l*LANE_W +: LANE_W] =
              wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RF_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop  <= we && (state != RF_IDLE);
      clr_done <= 1'b0;
      unique case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state    <= RF_CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        RF_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state    <= RF_DONE;
            clr_done <= 1'b1;
          end
        end
        RF_DONE: begin
          state    <= RF_IDLE;
          clr_busy <= 1'b0;
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

endmodule
